// File: rtl/axil_cmd_slave_pkg.sv
// Shared constants for the AXI4-Lite command slave: response codes, address map,
// control-register bit positions and FSM encoding.
package axil_cmd_slave_pkg;
  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  localparam int CTRL_ADDR_DEF = 0;
  localparam int CMD_ADDR_DEF  = 1;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_START = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_RESP   = 2'd2
  } state_e;
endpackage

// File: rtl/axil_cmd_slave_fifo.sv
// Synchronous first-word-fall-through command FIFO with flush and occupancy level.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic          push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  // Flush wins over any same-cycle push or pop.
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      level_q <= level_q + LW'(push_ok) - LW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= data_i;
  end

  assign data_o  = mem[rd_q];
  assign level_o = level_q;
endmodule

// File: rtl/axil_cmd_slave.sv
// AXI4-Lite write responder: captures AW/W independently, commits to the command
// FIFO or control register, then holds the B response until accepted.
module axil_cmd_slave
  import axil_cmd_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CMD_ADDR   = CMD_ADDR_DEF,
  parameter int CTRL_ADDR  = CTRL_ADDR_DEF
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic [ADDR_WIDTH-1:0]         iAWADDR,
  input  logic [2:0]                    iAWPROT,
  input  logic                          iAWVALID,
  output logic                          iAWREADY,
  input  logic [DATA_WIDTH-1:0]         iWDATA,
  input  logic [DATA_WIDTH/8-1:0]       iWSTRB,
  input  logic                          iWVALID,
  output logic                          iWREADY,
  input  logic                          iBREADY,
  output logic [1:0]                    iBRESP,
  output logic                          iBVALID,
  output logic [DATA_WIDTH-1:0]         cmd_data,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          start_pulse
);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] CMD_A  = ADDR_WIDTH'(CMD_ADDR);
  localparam logic [ADDR_WIDTH-1:0] CTRL_A = ADDR_WIDTH'(CTRL_ADDR);

  state_e                 state_q, state_d;
  logic                   aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [SW-1:0]          strb_q, strb_d;
  logic                   awready_q, awready_d, wready_q, wready_d;
  logic                   bvalid_q, bvalid_d, start_q, start_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   push, flush, fifo_full, fifo_empty;
  logic                   aw_hs, w_hs;

  assign aw_hs = iAWVALID & awready_q;
  assign w_hs  = iWVALID & wready_q;

  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    start_d   = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          addr_d    = iAWADDR;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          data_d   = iWDATA;
          strb_d   = iWSTRB;
        end
        if (aw_held_d && w_held_d) state_d = ST_COMMIT;
        awready_d = ~aw_held_d;
        wready_d  = ~w_held_d;
      end
      ST_COMMIT: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        if (!strb_q[0]) begin
          bresp_d  = BRESP_OKAY;
          bvalid_d = 1'b1;
          state_d  = ST_RESP;
        end else if (addr_q == CMD_A) begin
          // A full FIFO back-pressures the write here rather than dropping it.
          if (!fifo_full) begin
            push     = 1'b1;
            bresp_d  = BRESP_OKAY;
            bvalid_d = 1'b1;
            state_d  = ST_RESP;
          end
        end else if (addr_q == CTRL_A) begin
          flush    = data_q[CTRL_FLUSH];
          start_d  = data_q[CTRL_START];
          bresp_d  = BRESP_OKAY;
          bvalid_d = 1'b1;
          state_d  = ST_RESP;
        end else begin
          bresp_d  = BRESP_SLVERR;
          bvalid_d = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (iBREADY) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      state_q   <= ST_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= BRESP_OKAY;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      start_q   <= start_d;
    end
  end

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_WIDTH)) u_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .push_i  (push),
    .data_i  (data_q),
    .pop_i   (cmd_ready),
    .flush_i (flush),
    .data_o  (cmd_data),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  logic unused_ok;
  assign unused_ok = ^{iAWPROT, strb_q};

  assign iAWREADY    = awready_q;
  assign iWREADY     = wready_q;
  assign iBVALID     = bvalid_q;
  assign iBRESP      = bresp_q;
  assign cmd_valid   = ~fifo_empty;
  assign start_pulse = start_q;
endmodule

// File: tb/tb_axil_cmd_slave.sv
// Directed bench for axil_cmd_slave: handshake ordering, FIFO back-pressure,
// control register, error response and reset during a pending response.
module tb_axil_cmd_slave;
  logic       clk = 1'b0;
  logic       nreset = 1'b1;
  logic [7:0] iAWADDR = '0;
  logic [2:0] iAWPROT = '0;
  logic       iAWVALID = 1'b0;
  logic       iAWREADY;
  logic [7:0] iWDATA = '0;
  logic [0:0] iWSTRB = '0;
  logic       iWVALID = 1'b0;
  logic       iWREADY;
  logic       iBREADY = 1'b0;
  logic [1:0] iBRESP;
  logic       iBVALID;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready = 1'b0;
  logic [4:0] fifo_level;
  logic       start_pulse;

  int pass_cnt = 0;
  int total    = 0;
  int pulses   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (start_pulse === 1'b1) pulses++;

  axil_cmd_slave dut (
    .clk(clk), .nreset(nreset),
    .iAWADDR(iAWADDR), .iAWPROT(iAWPROT), .iAWVALID(iAWVALID), .iAWREADY(iAWREADY),
    .iWDATA(iWDATA), .iWSTRB(iWSTRB), .iWVALID(iWVALID), .iWREADY(iWREADY),
    .iBREADY(iBREADY), .iBRESP(iBRESP), .iBVALID(iBVALID),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .fifo_level(fifo_level), .start_pulse(start_pulse)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [7:0] d, input logic s,
                           output logic [1:0] resp);
    bit ad, wd, aa, ww, got;
    ad = 0; wd = 0; got = 0; resp = 2'bxx;
    iAWADDR = a; iWDATA = d; iWSTRB = s; iAWVALID = 1; iWVALID = 1; iBREADY = 1;
    for (int n = 0; n < 40 && !(ad && wd); n++) begin
      aa = iAWVALID & iAWREADY;
      ww = iWVALID & iWREADY;
      tick();
      if (aa) begin iAWVALID = 0; ad = 1; end
      if (ww) begin iWVALID = 0; wd = 1; end
    end
    iAWVALID = 0; iWVALID = 0;
    total++;
    if (!(ad && wd)) $display("FAIL wr_handshake addr=%h: aw=%0d w=%0d required 1 1", a, ad, wd);
    else pass_cnt++;
    for (int n = 0; n < 40 && !got; n++) begin
      if (iBVALID) begin resp = iBRESP; got = 1; end
      tick();
    end
    total++;
    if (!got) $display("FAIL wr_bvalid_timeout addr=%h: no BVALID within 40 cycles", a);
    else pass_cnt++;
  endtask

  task automatic drain;
    cmd_ready = 1;
    for (int n = 0; n < 64 && cmd_valid; n++) tick();
    cmd_ready = 0;
  endtask

  task automatic test_reset;
    nreset = 1;
    repeat (3) tick();
    total++;
    if ({iAWREADY, iWREADY, iBVALID, iBRESP, cmd_valid, start_pulse} !== 7'b0 || fifo_level !== 5'd0)
      $display("FAIL reset_outputs: aw=%b w=%b bv=%b br=%b cv=%b sp=%b lvl=%0d required all 0",
               iAWREADY, iWREADY, iBVALID, iBRESP, cmd_valid, start_pulse, fifo_level);
    else pass_cnt++;
    nreset = 0;
    tick();
    total++;
    if (iAWREADY !== 1'b1 || iWREADY !== 1'b1)
      $display("FAIL reset_release_ready: aw=%b w=%b required 1 1", iAWREADY, iWREADY);
    else pass_cnt++;
  endtask

  task automatic test_first_write;
    iAWADDR = 8'h01; iWDATA = 8'h50; iWSTRB = 1; iAWVALID = 1; iWVALID = 1; iBREADY = 1;
    tick();
    iAWVALID = 0; iWVALID = 0;
    total++;
    if (iBVALID !== 1'b0 || iAWREADY !== 1'b0 || iWREADY !== 1'b0)
      $display("FAIL first_commit_state: bv=%b aw=%b w=%b required 0 0 0", iBVALID, iAWREADY, iWREADY);
    else pass_cnt++;
    tick();
    total++;
    if (iBVALID !== 1'b1 || iBRESP !== 2'b00)
      $display("FAIL first_bresp: bv=%b br=%b required 1 00", iBVALID, iBRESP);
    else pass_cnt++;
    total++;
    if (cmd_valid !== 1'b1 || cmd_data !== 8'h50 || fifo_level !== 5'd1)
      $display("FAIL first_fifo: cv=%b data=%h lvl=%0d required 1 50 1", cmd_valid, cmd_data, fifo_level);
    else pass_cnt++;
    tick();
    total++;
    if (iBVALID !== 1'b0) $display("FAIL first_bvalid_drop: bv=%b required 0", iBVALID);
    else pass_cnt++;
    total++;
    if (iAWREADY !== 1'b1 || iWREADY !== 1'b1)
      $display("FAIL first_ready_return: aw=%b w=%b required 1 1", iAWREADY, iWREADY);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_w_first;
    bit bad;
    iWDATA = 8'h30; iWSTRB = 1; iWVALID = 1; iBREADY = 1;
    tick();
    iWVALID = 0;
    total++;
    if (iWREADY !== 1'b0 || iAWREADY !== 1'b1)
      $display("FAIL wfirst_held: w=%b aw=%b required 0 1", iWREADY, iAWREADY);
    else pass_cnt++;
    tick(); tick();
    iAWADDR = 8'h01; iAWVALID = 1;
    tick();
    iAWVALID = 0;
    tick();
    total++;
    if (iBVALID !== 1'b1 || iBRESP !== 2'b00 || fifo_level !== 5'd1 || cmd_data !== 8'h30)
      $display("FAIL wfirst_commit: bv=%b br=%b lvl=%0d data=%h required 1 00 1 30",
               iBVALID, iBRESP, fifo_level, cmd_data);
    else pass_cnt++;
    bad = 0;
    repeat (3) begin tick(); if (iBVALID !== 1'b0 || fifo_level !== 5'd1) bad = 1; end
    total++;
    if (bad) $display("FAIL wfirst_single: bv=%b lvl=%0d required 0 1", iBVALID, fifo_level);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_full;
    logic [1:0] r;
    logic [7:0] exp;
    bit bad, rbad;
    cmd_ready = 0; rbad = 0;
    for (int i = 0; i < 16; i++) begin
      axi_write(8'h01, 8'(i), 1'b1, r);
      if (r !== 2'b00) rbad = 1;
    end
    total++;
    if (rbad || fifo_level !== 5'd16 || cmd_data !== 8'h00)
      $display("FAIL full_fill: rbad=%0d lvl=%0d data=%h required 0 16 00", rbad, fifo_level, cmd_data);
    else pass_cnt++;
    iAWADDR = 8'h01; iWDATA = 8'hE0; iWSTRB = 1; iAWVALID = 1; iWVALID = 1; iBREADY = 1;
    tick();
    iAWVALID = 0; iWVALID = 0;
    bad = 0;
    repeat (5) begin tick(); if (iBVALID !== 1'b0 || fifo_level !== 5'd16) bad = 1; end
    total++;
    if (bad) $display("FAIL full_stall: bv=%b lvl=%0d required 0 16", iBVALID, fifo_level);
    else pass_cnt++;
    cmd_ready = 1;
    tick();
    cmd_ready = 0;
    total++;
    if (fifo_level !== 5'd15 || iBVALID !== 1'b0)
      $display("FAIL full_pop: lvl=%0d bv=%b required 15 0", fifo_level, iBVALID);
    else pass_cnt++;
    tick();
    total++;
    if (fifo_level !== 5'd16 || iBVALID !== 1'b1 || iBRESP !== 2'b00)
      $display("FAIL full_late_commit: lvl=%0d bv=%b br=%b required 16 1 00", fifo_level, iBVALID, iBRESP);
    else pass_cnt++;
    tick();
    cmd_ready = 1; bad = 0;
    for (int i = 1; i <= 16; i++) begin
      exp = (i < 16) ? 8'(i) : 8'hE0;
      if (cmd_valid !== 1'b1 || cmd_data !== exp) begin
        if (!bad) $display("FAIL full_drain_order idx=%0d: data=%h cv=%b required %h 1", i, cmd_data, cmd_valid, exp);
        bad = 1;
      end
      tick();
    end
    cmd_ready = 0;
    total++;
    if (bad || fifo_level !== 5'd0 || cmd_valid !== 1'b0)
      $display("FAIL full_drain_end: bad=%0d lvl=%0d cv=%b required 0 0 0", bad, fifo_level, cmd_valid);
    else pass_cnt++;
  endtask

  task automatic test_unmapped_strb0;
    logic [1:0] r;
    int p0;
    axi_write(8'h01, 8'h11, 1'b1, r);
    p0 = pulses;
    axi_write(8'h7F, 8'hAA, 1'b1, r);
    total++;
    if (r !== 2'b10) $display("FAIL unmapped_bresp: got %b required 10", r);
    else pass_cnt++;
    total++;
    if (fifo_level !== 5'd1 || cmd_data !== 8'h11 || pulses !== p0)
      $display("FAIL unmapped_noeffect: lvl=%0d data=%h pulses=%0d required 1 11 %0d",
               fifo_level, cmd_data, pulses, p0);
    else pass_cnt++;
    axi_write(8'h01, 8'h22, 1'b0, r);
    total++;
    if (r !== 2'b00 || fifo_level !== 5'd1)
      $display("FAIL strb0_write: br=%b lvl=%0d required 00 1", r, fifo_level);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_ctrl;
    logic [1:0] r;
    int p0;
    cmd_ready = 0;
    axi_write(8'h01, 8'hA1, 1'b1, r);
    axi_write(8'h01, 8'hA2, 1'b1, r);
    axi_write(8'h01, 8'hA3, 1'b1, r);
    total++;
    if (fifo_level !== 5'd3) $display("FAIL ctrl_queue: lvl=%0d required 3", fifo_level);
    else pass_cnt++;
    p0 = pulses;
    iAWADDR = 8'h00; iWDATA = 8'h03; iWSTRB = 1; iAWVALID = 1; iWVALID = 1; iBREADY = 1;
    cmd_ready = 1;
    tick();
    iAWVALID = 0; iWVALID = 0;
    total++;
    if (start_pulse !== 1'b0) $display("FAIL ctrl_early_pulse: sp=%b required 0", start_pulse);
    else pass_cnt++;
    tick();
    total++;
    if (fifo_level !== 5'd0 || cmd_valid !== 1'b0 || start_pulse !== 1'b1 || iBVALID !== 1'b1 || iBRESP !== 2'b00)
      $display("FAIL ctrl_commit: lvl=%0d cv=%b sp=%b bv=%b br=%b required 0 0 1 1 00",
               fifo_level, cmd_valid, start_pulse, iBVALID, iBRESP);
    else pass_cnt++;
    tick();
    total++;
    if (start_pulse !== 1'b0 || iBVALID !== 1'b0)
      $display("FAIL ctrl_pulse_end: sp=%b bv=%b required 0 0", start_pulse, iBVALID);
    else pass_cnt++;
    cmd_ready = 0;
    tick();
    total++;
    if (pulses !== p0 + 1) $display("FAIL ctrl_pulse_count: got %0d required %0d", pulses - p0, 1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_resp;
    bit bad;
    iBREADY = 0;
    iAWADDR = 8'h01; iWDATA = 8'h5A; iWSTRB = 1; iAWVALID = 1; iWVALID = 1;
    tick();
    iAWVALID = 0; iWVALID = 0;
    tick();
    total++;
    if (iBVALID !== 1'b1 || iBRESP !== 2'b00)
      $display("FAIL hold_bvalid: bv=%b br=%b required 1 00", iBVALID, iBRESP);
    else pass_cnt++;
    bad = 0;
    repeat (5) begin
      tick();
      if (iBVALID !== 1'b1 || iBRESP !== 2'b00 || iAWREADY !== 1'b0 || iWREADY !== 1'b0) bad = 1;
    end
    total++;
    if (bad) $display("FAIL hold_stable: bv=%b br=%b aw=%b w=%b required 1 00 0 0",
                      iBVALID, iBRESP, iAWREADY, iWREADY);
    else pass_cnt++;
    nreset = 1;
    #1;
    total++;
    if ({iAWREADY, iWREADY, iBVALID, iBRESP, cmd_valid, start_pulse} !== 7'b0 || fifo_level !== 5'd0)
      $display("FAIL midreset_outputs: aw=%b w=%b bv=%b br=%b cv=%b sp=%b lvl=%0d required all 0",
               iAWREADY, iWREADY, iBVALID, iBRESP, cmd_valid, start_pulse, fifo_level);
    else pass_cnt++;
    iBREADY = 1;
    tick(); tick();
    nreset = 0;
    tick();
    total++;
    if (iAWREADY !== 1'b1 || iWREADY !== 1'b1 || iBVALID !== 1'b0)
      $display("FAIL midreset_release: aw=%b w=%b bv=%b required 1 1 0", iAWREADY, iWREADY, iBVALID);
    else pass_cnt++;
    bad = 0;
    repeat (3) begin tick(); if (iBVALID !== 1'b0 || fifo_level !== 5'd0) bad = 1; end
    total++;
    if (bad) $display("FAIL midreset_no_resp: bv=%b lvl=%0d required 0 0", iBVALID, fifo_level);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_w_first();
    test_full();
    test_unmapped_strb0();
    test_ctrl();
    test_reset_mid_resp();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
